// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter with a registered one-hot grant.
// Round-robin or fixed priority (chosen while idle), grant held while the
// owner keeps its request, optional hold-timeout preemption when others wait.
// A release or preemption always returns to IDLE, which gives one all-zero
// grant cycle of bus turnaround between owners.
module bus_arbiter_rr #(
  parameter int N_MASTERS = 4,
  parameter int MAX_HOLD  = 16,
  localparam int IDXW     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode_fixed,
  input  logic [N_MASTERS-1:0] req,
  input  logic                 busbusy,
  output logic [N_MASTERS-1:0] grant,
  output logic                 grant_valid,
  output logic [IDXW-1:0]      grant_idx,
  output logic                 preempt,
  output logic [IDXW-1:0]      dbg_ptr
);

  // Counter stops at MAX_HOLD-1 so a late second requester still triggers
  // the timeout compare on the following edge.
  localparam int CNT_MAX = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam int CNTW    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {S_IDLE, S_GRANTED} state_t;

  state_t                r_state, w_state_nxt;
  logic [N_MASTERS-1:0]  r_grant, w_grant_nxt;
  logic [IDXW-1:0]       r_idx, w_idx_nxt;
  logic [IDXW-1:0]       r_ptr, w_ptr_nxt;
  logic [CNTW-1:0]       r_cnt, w_cnt_nxt;
  logic                  r_preempt, w_preempt_nxt;

  logic [IDXW-1:0]       w_win_rr, w_win_fix, w_win;
  logic [IDXW-1:0]       w_owner_inc;
  logic                  w_req_owner, w_others, w_timeout;

  // Round-robin winner: first set request searching upward from the pointer.
  always_comb begin
    logic found;
    found    = 1'b0;
    w_win_rr = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      int j;
      j = int'(r_ptr) + i;
      if (j >= N_MASTERS) j = j - N_MASTERS;
      if (!found && req[j]) begin
        found    = 1'b1;
        w_win_rr = IDXW'(j);
      end
    end
  end

  // Fixed-priority winner: lowest set index.
  always_comb begin
    w_win_fix = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) w_win_fix = IDXW'(i);
    end
  end

  assign w_win       = mode_fixed ? w_win_fix : w_win_rr;
  assign w_owner_inc = (r_idx == IDXW'(N_MASTERS - 1)) ? '0 : r_idx + 1'b1;
  assign w_req_owner = req[r_idx];
  assign w_others    = |(req & ~r_grant);
  assign w_timeout   = (MAX_HOLD > 0) && (r_cnt == CNTW'(CNT_MAX)) &&
                       w_req_owner && w_others;

  // Next-state and next-output logic for the IDLE/GRANTED machine.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_idx_nxt     = r_idx;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_preempt_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        if (!busbusy && (|req)) begin
          w_grant_nxt        = '0;
          w_grant_nxt[w_win] = 1'b1;
          w_idx_nxt          = w_win;
          w_cnt_nxt          = '0;
          w_state_nxt        = S_GRANTED;
        end
      end
      S_GRANTED: begin
        if (!w_req_owner) begin
          // release wins over a coincident timeout: no preempt pulse
          w_grant_nxt = '0;
          w_ptr_nxt   = w_owner_inc;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_grant_nxt   = '0;
          w_ptr_nxt     = w_owner_inc;
          w_preempt_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else if (r_cnt != CNTW'(CNT_MAX)) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_idx     <= w_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = |r_grant;
  assign grant_idx   = r_idx;
  assign preempt     = r_preempt;
  assign dbg_ptr     = r_ptr;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr (4 masters, 8-cycle hold timeout).
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_fixed;
  logic [3:0] req;
  logic       busbusy;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic       preempt;
  logic [1:0] dbg_ptr;

  int checks = 0;
  int errors = 0;

  bus_arbiter_rr #(.N_MASTERS(4), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .mode_fixed(mode_fixed), .req(req),
    .busbusy(busbusy), .grant(grant), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .preempt(preempt), .dbg_ptr(dbg_ptr)
  );

  always #5 clk = ~clk;

  // advance one edge, then settle so registered outputs can be sampled
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; busbusy = 1'b0; mode_fixed = 1'b0;
    step(); step();
    checks++;
    if (grant !== 4'b0 || grant_valid !== 1'b0 || grant_idx !== 2'd0 ||
        preempt !== 1'b0 || dbg_ptr !== 2'd0) begin
      errors++;
      $display("FAIL reset_values grant=%b gv=%b idx=%0d pre=%b ptr=%0d",
               grant, grant_valid, grant_idx, preempt, dbg_ptr);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (grant !== 4'b0 || grant_valid !== 1'b0 || dbg_ptr !== 2'd0 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL idle_noreq c=%0d grant=%b gv=%b ptr=%0d pre=%b want 0000/0/0/0",
                 c, grant, grant_valid, dbg_ptr, preempt);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    mode_fixed = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int o;
      o = k % 4;
      exp = 4'b0001 << o;
      for (int c = 0; c < 3; c++) begin
        step();
        checks++;
        if (grant !== exp || grant_idx !== 2'(o) || grant_valid !== 1'b1) begin
          errors++;
          $display("FAIL rr_grant k=%0d c=%0d grant=%b idx=%0d want %b idx=%0d",
                   k, c, grant, grant_idx, exp, o);
        end
      end
      req[o] = 1'b0;
      step();
      checks++;
      if (grant !== 4'b0 || grant_valid !== 1'b0 || dbg_ptr !== 2'((o + 1) % 4) ||
          grant_idx !== 2'(o)) begin
        errors++;
        $display("FAIL rr_release k=%0d grant=%b ptr=%0d idx=%0d want 0000 ptr=%0d idx=%0d",
                 k, grant, dbg_ptr, grant_idx, (o + 1) % 4, o);
      end
      req[o] = 1'b1;
    end
  endtask

  task automatic test_fixed();
    mode_fixed = 1'b1;
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 2; c++) begin
        step();
        checks++;
        if (grant !== 4'b0010) begin
          errors++;
          $display("FAIL fixed_grant k=%0d c=%0d grant=%b want 0010", k, c, grant);
        end
      end
      req[1] = 1'b0;
      step();
      checks++;
      if (grant !== 4'b0000) begin
        errors++;
        $display("FAIL fixed_release k=%0d grant=%b want 0000", k, grant);
      end
      req[1] = 1'b1;
    end
    req = 4'b0000;
    mode_fixed = 1'b0;
    step();
    checks++;
    if (grant !== 4'b0 || dbg_ptr !== 2'd2) begin
      errors++;
      $display("FAIL fixed_end grant=%b ptr=%0d want 0000 ptr=2", grant, dbg_ptr);
    end
  endtask

  task automatic test_busbusy();
    busbusy = 1'b1;
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (grant !== 4'b0) begin
        errors++;
        $display("FAIL busy_block c=%0d grant=%b want 0000", c, grant);
      end
    end
    busbusy = 1'b0;
    step();
    checks++;
    if (grant !== 4'b0100 || grant_idx !== 2'd2) begin
      errors++;
      $display("FAIL busy_drop grant=%b idx=%0d want 0100 idx=2", grant, grant_idx);
    end
    busbusy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (grant !== 4'b0100) begin
        errors++;
        $display("FAIL busy_hold c=%0d grant=%b want 0100", c, grant);
      end
    end
    req = 4'b0; busbusy = 1'b0;
    step();
    checks++;
    if (grant !== 4'b0 || dbg_ptr !== 2'd3) begin
      errors++;
      $display("FAIL busy_release grant=%b ptr=%0d want 0000 ptr=3", grant, dbg_ptr);
    end
  endtask

  task automatic test_timeout();
    req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++;
      if (grant !== 4'b0001 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL to_hold cycle=%0d grant=%b pre=%b want 0001/0", c, grant, preempt);
      end
      if (c == 2) req = 4'b0101;
    end
    step();
    checks++;
    if (grant !== 4'b0 || preempt !== 1'b1 || dbg_ptr !== 2'd1) begin
      errors++;
      $display("FAIL to_preempt grant=%b pre=%b ptr=%0d want 0000/1/1", grant, preempt, dbg_ptr);
    end
    step();
    checks++;
    if (grant !== 4'b0100 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL to_next grant=%b pre=%b want 0100/0", grant, preempt);
    end
    req = 4'b0;
    step();
    checks++;
    if (grant !== 4'b0 || preempt !== 1'b0 || dbg_ptr !== 2'd3) begin
      errors++;
      $display("FAIL to_release grant=%b pre=%b ptr=%0d want 0000/0/3", grant, preempt, dbg_ptr);
    end
  endtask

  task automatic test_saturate();
    req = 4'b0010;
    for (int c = 0; c < 12; c++) begin
      step();
      checks++;
      if (grant !== 4'b0010 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL sat_hold c=%0d grant=%b pre=%b want 0010/0", c, grant, preempt);
      end
    end
    req = 4'b1010;
    step();
    checks++;
    if (grant !== 4'b0 || preempt !== 1'b1 || dbg_ptr !== 2'd2) begin
      errors++;
      $display("FAIL sat_preempt grant=%b pre=%b ptr=%0d want 0000/1/2", grant, preempt, dbg_ptr);
    end
    req = 4'b1000;
    step();
    checks++;
    if (grant !== 4'b1000 || grant_idx !== 2'd3 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL sat_next grant=%b idx=%0d pre=%b want 1000/3/0", grant, grant_idx, preempt);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0 || grant_valid !== 1'b0 || dbg_ptr !== 2'd0 ||
        grant_idx !== 2'd0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL async_rst grant=%b gv=%b ptr=%0d idx=%0d pre=%b want all 0",
               grant, grant_valid, dbg_ptr, grant_idx, preempt);
    end
    req = 4'b1001;
    step();
    checks++;
    if (grant !== 4'b0) begin
      errors++;
      $display("FAIL rst_held grant=%b want 0000", grant);
    end
    rst = 1'b0;
    step();
    checks++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL post_rst grant=%b idx=%0d want 0001/0", grant, grant_idx);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed();
    test_busbusy();
    test_timeout();
    test_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1);
  end

endmodule
